mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store sequencer directly upstream of the word-wide data memory. It accepts byte, halfword and word requests from the datapath and drives the word-only memory port. It performs read-modify-write for sub-word stores and lane extraction plus sign/zero extension for loads. All memory control strobes come from flops, so the combinational memory never sees a glitching write enable.

Parameters:
ADDR_W, 32, byte-address width of requests; the memory word address is req_addr[ADDR_W-1:2] zero-extended to 32 bits.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal (treated as misaligned)
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores
resp_misaligned  out  1  error flag, valid with resp_valid
mem_address  out  32  word address to memory
mem_writeData  out  32  word to write
mem_memWrite  out  1  memory write strobe
mem_memRead  out  1  memory read strobe
mem_readData  in  32  word returned combinationally by memory

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1; latched request cleared. Reset mid-operation aborts immediately and drops mem_memWrite asynchronously. Any RMW in flight is lost; no partial write occurs.
- Accept: req_valid && req_ready at a rising edge latches write, size, unsigned, addr, wdata. req_valid is ignored outside IDLE.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Goes IDLE->RESP with resp_misaligned=1, no memory strobe, resp_rdata=0.
- FSM paths:
  - load: IDLE->LOAD_RD->RESP
  - sub-word store: IDLE->STORE_RD->STORE_WR->RESP
  - word store: IDLE->STORE_WR->RESP
  - RESP always returns to IDLE.
- LOAD_RD / STORE_RD: mem_memRead=1 for exactly one cycle with mem_address stable. mem_readData is sampled at the closing edge.
- STORE_WR: mem_memWrite=1 for exactly one cycle. mem_address and mem_writeData are driven from flops and stable the whole cycle.
- Strobes: never both high. Both 0 in IDLE and RESP. mem_address and mem_writeData hold their last value when idle.
- Lanes are little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane]
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]]
- Store merge: replace only the addressed lane with req_wdata[7:0] or [15:0]; other lanes keep the read value.
- Load extract: lane value zero-extended (unsigned) or sign-extended from bit 7/15 (signed). A word passes unchanged.
- RESP: resp_valid=1 for one cycle; resp_rdata and resp_misaligned are registered. Next accept is possible the cycle after RESP.
- Latency from accepting edge k:
  - misaligned: resp_valid in cycle k+1
  - load and word store: k+2
  - sub-word store: k+3
- Throughput: at most one request per (latency+1) cycles. No pipelining, no queue.

Optional Feature:
MAU_STATS_EN
- Defined: adds outputs ld_count[15:0] and st_count[15:0], reset to 0. Each increments in the RESP cycle for a non-misaligned load or store respectively, and wraps 0xFFFF->0x0000.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Word store/load: store 0xDEADBEEF @0x10, then signed word load @0x10 -> mem_memWrite high one cycle with mem_address=0x4; resp_rdata=0xDEADBEEF at k+2.
- Byte RMW: with word 0x4 = 0x11223344, store byte 0xAA @0x12 -> STORE_RD then STORE_WR writes 0x11AA3344; resp_valid at k+3.
- Sign extension, word 0x4=0x11AA3344:
  - signed byte load @0x12 -> 0xFFFFFFAA
  - unsigned byte load @0x12 -> 0x000000AA
  - signed half load @0x12 -> 0x000011AA
- Misaligned: word load @0x13 and half store @0x11 -> resp_misaligned=1 at k+1, both strobes stay 0, memory unchanged.
- Busy/back-to-back: req_valid held high across two requests -> req_ready low from accept until after RESP; second request accepted in the cycle after RESP; strobes never overlap.
- Reset mid-op: deassert rst_n during STORE_WR -> mem_memWrite falls immediately, req_ready=1, resp_valid=0. With MAU_STATS_EN defined, st_count reads 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer in front of a word-only data memory (RMW for sub-word stores).
// Latency from accept edge k: misaligned k+1, load and word store k+2, sub-word store k+3.
// Backpressure: req_ready is high only in IDLE, one request in flight. Optional MAU_STATS_EN adds ld/st counters.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic [31:0]       mem_address,
   output logic [31:0]       mem_writeData,
   output logic              mem_memWrite,
   output logic              mem_memRead,
   input  logic [31:0]       mem_readData
`ifdef MAU_STATS_EN
   ,
   output logic [15:0]       ld_count,
   output logic [15:0]       st_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_RD, S_STORE_RD, S_STORE_WR, S_RESP
   } state_t;

   state_t      state, next_state;
   logic        accept, misaligned;
   logic [31:0] word_addr;

   // Latched request fields used after the accept edge
   logic        lat_write;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic [1:0]  lat_addr_lo;
   logic [15:0] lat_wdata;

   // Pull the addressed lane out of a memory word and extend it to 32 bits
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lo,
                                                input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*lo +: 8];
      h = w[16*lo[1] +: 16];
      case (sz)
         2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   // Replace only the addressed lane of the read word with the store data
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic [15:0] wd);
      logic [31:0] m;
      m = w;
      if (sz == 2'b00) m[8*lo +: 8] = wd[7:0];
      else             m[16*lo[1] +: 16] = wd;
      return m;
   endfunction

   // Accept decode, alignment check and word-address formation
   always_comb begin
      accept     = req_valid && (state == S_IDLE);
      misaligned = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
      word_addr  = '0;
      word_addr[ADDR_W-3:0] = req_addr[ADDR_W-1:2];
   end

   // Next-state selection
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (misaligned)              next_state = S_RESP;
               else if (!req_write)         next_state = S_LOAD_RD;
               else if (req_size == 2'b10)  next_state = S_STORE_WR;
               else                         next_state = S_STORE_RD;
            end
         end
         S_LOAD_RD:  next_state = S_RESP;
         S_STORE_RD: next_state = S_STORE_WR;
         S_STORE_WR: next_state = S_RESP;
         default:    next_state = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Registered strobes, handshake outputs and datapath; strobes are decoded from next_state
   // so the memory sees clean flop outputs for the whole cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         mem_address     <= '0;
         mem_writeData   <= '0;
         mem_memWrite    <= 1'b0;
         mem_memRead     <= 1'b0;
         lat_write       <= 1'b0;
         lat_size        <= '0;
         lat_unsigned    <= 1'b0;
         lat_addr_lo     <= '0;
         lat_wdata       <= '0;
      end else begin
         req_ready    <= (next_state == S_IDLE);
         resp_valid   <= (next_state == S_RESP);
         mem_memRead  <= (next_state == S_LOAD_RD) || (next_state == S_STORE_RD);
         mem_memWrite <= (next_state == S_STORE_WR);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_write       <= req_write;
                  lat_size        <= req_size;
                  lat_unsigned    <= req_unsigned;
                  lat_addr_lo     <= req_addr[1:0];
                  lat_wdata       <= req_wdata[15:0];
                  resp_rdata      <= '0;
                  resp_misaligned <= misaligned;
                  // Misaligned requests never touch the memory port
                  if (!misaligned) mem_address <= word_addr;
                  if (!misaligned && req_write && (req_size == 2'b10)) mem_writeData <= req_wdata;
               end
            end
            S_LOAD_RD:  resp_rdata <= load_extract(mem_readData, lat_addr_lo, lat_size, lat_unsigned);
            S_STORE_RD: mem_writeData <= store_merge(mem_readData, lat_addr_lo, lat_size, lat_wdata);
            S_RESP: begin
               resp_rdata      <= '0;
               resp_misaligned <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef MAU_STATS_EN
   // Completed-access counters, bumped as the response cycle closes; wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_count <= '0;
         st_count <= '0;
      end else if ((state == S_RESP) && !resp_misaligned) begin
         if (lat_write) st_count <= st_count + 16'd1;
         else           ld_count <= ld_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model on the memory port.
// Requests are driven on the falling edge and responses sampled on the falling edge.
// Optional MAU_STATS_EN counters are checked only when the macro is defined.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic [31:0] mem_address;
   logic [31:0] mem_writeData;
   logic        mem_memWrite;
   logic        mem_memRead;
   logic [31:0] mem_readData;
`ifdef MAU_STATS_EN
   logic [15:0] ld_count;
   logic [15:0] st_count;
`endif

   int checks = 0;
   int failures = 0;

   // Memory model and strobe monitor
   logic [31:0] mem [0:15];
   logic        clr_mem = 1'b1;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          overlap_cnt = 0;
   logic [31:0] last_wr_addr = '0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned), .mem_address(mem_address),
      .mem_writeData(mem_writeData), .mem_memWrite(mem_memWrite),
      .mem_memRead(mem_memRead), .mem_readData(mem_readData)
`ifdef MAU_STATS_EN
      , .ld_count(ld_count), .st_count(st_count)
`endif
   );

   assign mem_readData = mem[mem_address[3:0]];

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (mem_memWrite) begin
         mem[mem_address[3:0]] <= mem_writeData;
      end
   end

   always @(negedge clk) begin
      if (mem_memWrite && mem_memRead) overlap_cnt++;
      if (mem_memWrite) begin
         wr_cnt++;
         last_wr_addr = mem_address;
      end
      if (mem_memRead) rd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request and wait (bounded) for its response
   task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_mis,
                      input int exp_wr, input int exp_rds);
      int lat;
      int wr0, rd0;
      logic [31:0] rd;
      logic mis;
      lat = 0; rd = '0; mis = 1'b0;
      @(negedge clk);
      wr0 = wr_cnt; rd0 = rd_cnt;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = n; rd = resp_rdata; mis = resp_misaligned;
            break;
         end
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_mis"}, {31'b0, mis}, {31'b0, exp_mis});
      check({tag, "_wr"}, wr_cnt - wr0, exp_wr);
      check({tag, "_rd"}, rd_cnt - rd0, exp_rds);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_strobes", {30'b0, mem_memWrite, mem_memRead}, 32'd0);
      check("rst_addr", mem_address, 32'd0);
      check("rst_wdata", mem_writeData, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      clr_mem = 1'b0;

      // Word store then word load
      run("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 1, 0);
      check("st_w_addr", last_wr_addr, 32'h4);
      check("st_w_mem", mem[4], 32'hDEADBEEF);
      run("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 0, 1);

      // Byte RMW into 0x11223344
      run("st_w2", 1, 2'b10, 0, 32'h10, 32'h11223344, 2, 32'h0, 0, 1, 0);
      run("st_b", 1, 2'b00, 0, 32'h12, 32'h000000AA, 3, 32'h0, 0, 1, 1);
      check("st_b_mem", mem[4], 32'h11AA3344);

      // Extraction and extension
      run("ld_bs", 0, 2'b00, 0, 32'h12, 32'h0, 2, 32'hFFFFFFAA, 0, 0, 1);
      run("ld_bu", 0, 2'b00, 1, 32'h12, 32'h0, 2, 32'h000000AA, 0, 0, 1);
      run("ld_hs", 0, 2'b01, 0, 32'h12, 32'h0, 2, 32'h000011AA, 0, 0, 1);
      run("ld_b3", 0, 2'b00, 0, 32'h13, 32'h0, 2, 32'h00000011, 0, 0, 1);
      run("st_b1", 1, 2'b00, 0, 32'h11, 32'h12345655, 3, 32'h0, 0, 1, 1);
      check("st_b1_mem", mem[4], 32'h11AA5544);
      run("st_h", 1, 2'b01, 0, 32'h16, 32'hABCD8001, 3, 32'h0, 0, 1, 1);
      check("st_h_mem", mem[5], 32'h80010000);
      run("ld_hs2", 0, 2'b01, 0, 32'h16, 32'h0, 2, 32'hFFFF8001, 0, 0, 1);
      run("ld_hu2", 0, 2'b01, 1, 32'h16, 32'h0, 2, 32'h00008001, 0, 0, 1);
      run("ld_hs0", 0, 2'b01, 0, 32'h10, 32'h0, 2, 32'h00005544, 0, 0, 1);

      // Misaligned cases
      run("mis_ldw", 0, 2'b10, 0, 32'h13, 32'h0, 1, 32'h0, 1, 0, 0);
      run("mis_sth", 1, 2'b01, 0, 32'h11, 32'hFFFF, 1, 32'h0, 1, 0, 0);
      check("mis_mem", mem[4], 32'h11AA5544);
      run("mis_sz3", 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0);

      // Back-to-back with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
      @(posedge clk);
      #1 req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h12;
      @(negedge clk);
      check("b2b_rdy1", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("b2b_rdy2", {31'b0, req_ready}, 32'd0);
      check("b2b_resp_a", {31'b0, resp_valid}, 32'd1);
      check("b2b_rdata_a", resp_rdata, 32'h11AA5544);
      @(negedge clk);
      check("b2b_rdy3", {31'b0, req_ready}, 32'd1);
      check("b2b_idle", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
      check("b2b_rdy4", {31'b0, req_ready}, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      check("b2b_resp_b", {31'b0, resp_valid}, 32'd1);
      check("b2b_rdata_b", resp_rdata, 32'h000000AA);
      check("overlap", overlap_cnt, 32'd0);

      // Reset in STORE_WR of a byte RMW
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h14; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rmid_wr_hi", {31'b0, mem_memWrite}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rmid_wr_lo", {31'b0, mem_memWrite}, 32'd0);
      check("rmid_ready", {31'b0, req_ready}, 32'd1);
      check("rmid_resp", {31'b0, resp_valid}, 32'd0);
`ifdef MAU_STATS_EN
      check("rmid_st_count", {16'b0, st_count}, 32'd0);
      check("rmid_ld_count", {16'b0, ld_count}, 32'd0);
`endif
      @(negedge clk);
      check("rmid_mem", mem[5], 32'h80010000);
      rst_n = 1'b1;
      run("post_rst", 0, 2'b10, 0, 32'h14, 32'h0, 2, 32'h80010000, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
